// File: rtl/sim_halt_monitor.sv
// sim_halt_monitor: multi-hart end-of-simulation controller with drain window, timeout and stall detection
module sim_halt_monitor #(
   parameter int NHART       = 1,
   parameter int XLEN        = 64,
   parameter int CNT_W       = 32,
   parameter int TIMEOUT     = 500000,
   parameter int STALL_LIMIT = 1024,
   parameter int DRAIN       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NHART-1:0]       commit,
   input  logic [NHART-1:0]       ebreak,
   input  logic [NHART*XLEN-1:0]  a0,
   output logic                   done,
   output logic [2:0]             code,
   output logic [NHART-1:0]       halted,
   output logic [NHART-1:0]       fail_mask,
   output logic [CNT_W-1:0]       cycles,
   output logic [NHART*CNT_W-1:0] instret
);
   localparam int DW = DRAIN > 0 ? $clog2(DRAIN + 1) : 1;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STALL_LIMIT > 0 ? STALL_LIMIT - 1 : 0);
   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
   state_t            state;
   logic [CNT_W-1:0]  stall;
   logic [DW-1:0]     dcnt;
   logic [NHART-1:0]  live, hit, nz, halted_n, fail_n;
   logic              all_halt, any_commit;
   // per-hart events that count this edge and the halt/verdict state they produce
   always_comb begin
      nz = '0;
      for (int h = 0; h < NHART; h++) nz[h] = |a0[h*XLEN +: XLEN];
      live       = commit & ~halted;
      hit        = live & ebreak;
      halted_n   = halted | hit;
      fail_n     = fail_mask | (hit & nz);
      all_halt   = &halted_n;
      any_commit = |live;
   end
   // RUN -> DRAIN -> DONE controller with saturating counters and registered verdict
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RUN;
         done      <= 1'b0;
         code      <= 3'd0;
         halted    <= '0;
         fail_mask <= '0;
         cycles    <= '0;
         instret   <= '0;
         stall     <= '0;
         dcnt      <= '0;
      end else begin
         case (state)
            S_RUN: begin
               halted    <= halted_n;
               fail_mask <= fail_n;
               for (int h = 0; h < NHART; h++)
                  if (live[h] && instret[h*CNT_W +: CNT_W] != '1)
                     instret[h*CNT_W +: CNT_W] <= instret[h*CNT_W +: CNT_W] + ONE;
               if (cycles != '1) cycles <= cycles + ONE;
               stall <= any_commit ? '0 : (stall != '1 ? stall + ONE : stall);
               if (all_halt) begin
                  dcnt <= '0;
                  if (DRAIN == 0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     code  <= fail_n != '0 ? 3'd2 : 3'd1;
                  end else begin
                     state <= S_DRAIN;
                  end
               end else if (cycles == TO_LAST) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  code  <= 3'd3;
               end else if (STALL_LIMIT != 0 && !any_commit && stall == ST_LAST) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  code  <= 3'd4;
               end
            end
            S_DRAIN: begin
               if (cycles != '1) cycles <= cycles + ONE;
               if (dcnt == DW'(DRAIN)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  code  <= fail_mask != '0 ? 3'd2 : 3'd1;
               end else begin
                  dcnt <= dcnt + DW'(1);
               end
            end
            default: begin
               state <= S_DONE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sim_halt_monitor.sv
// tb_sim_halt_monitor: directed checks of halt, drain, timeout, stall and reset behaviour
module tb_sim_halt_monitor;
   logic clk = 1'b0;
   logic rst0 = 1'b1, rst1 = 1'b1;
   logic c0 = 1'b0, e0 = 1'b0;
   logic [63:0] av0 = '0;
   logic [1:0] c1 = '0, e1 = '0;
   logic [31:0] av1 = '0;
   logic done0, done1;
   logic [2:0] code0, code1;
   logic halted0, fail0;
   logic [1:0] halted1, fail1;
   logic [31:0] cycles0, instret0;
   logic [15:0] cycles1;
   logic [31:0] instret1;
   int vecs = 0;
   int errs = 0;

   sim_halt_monitor #(.NHART(1), .XLEN(64), .CNT_W(32), .TIMEOUT(100), .STALL_LIMIT(8), .DRAIN(4)) u0 (
      .clk(clk), .rst(rst0), .commit(c0), .ebreak(e0), .a0(av0), .done(done0), .code(code0),
      .halted(halted0), .fail_mask(fail0), .cycles(cycles0), .instret(instret0));

   sim_halt_monitor #(.NHART(2), .XLEN(16), .CNT_W(16), .TIMEOUT(1000), .STALL_LIMIT(0), .DRAIN(0)) u1 (
      .clk(clk), .rst(rst1), .commit(c1), .ebreak(e1), .a0(av1), .done(done1), .code(code1),
      .halted(halted1), .fail_mask(fail1), .cycles(cycles1), .instret(instret1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic t0(input logic c, input logic e, input logic [63:0] a);
      c0 = c; e0 = e; av0 = a;
      @(posedge clk); #1;
   endtask

   task automatic t1(input logic [1:0] c, input logic [1:0] e, input logic [31:0] a);
      c1 = c; e1 = e; av1 = a;
      @(posedge clk); #1;
   endtask

   task automatic rst_u0();
      rst0 = 1'b1;
      t0(1'b0, 1'b0, 64'd0);
      rst0 = 1'b0;
   endtask

   task automatic run_a();
      rst_u0();
      chk("a_rst_done", done0, 0); chk("a_rst_code", code0, 0);
      chk("a_rst_instret", instret0, 0); chk("a_rst_cycles", cycles0, 0);
      repeat (10) t0(1'b1, 1'b0, 64'd0);
      t0(1'b1, 1'b1, 64'd0);
      chk("a_instret", instret0, 11); chk("a_halted", halted0, 1);
      chk("a_fail", fail0, 0); chk("a_done_T", done0, 0); chk("a_cycles_T", cycles0, 11);
      repeat (4) t0(1'b0, 1'b0, 64'd0);
      chk("a_done_T4", done0, 0); chk("a_code_T4", code0, 0);
      t0(1'b0, 1'b0, 64'd0);
      chk("a_done_T5", done0, 1); chk("a_code_T5", code0, 1); chk("a_cycles_T5", cycles0, 16);
      repeat (3) t0(1'b1, 1'b1, 64'd1);
      chk("a_cycles_frozen", cycles0, 16); chk("a_instret_frozen", instret0, 11);
      chk("a_code_sticky", code0, 1); chk("a_fail_frozen", fail0, 0);
   endtask

   initial begin
      run_a();
      // reset asserted in the middle of a drain window
      rst_u0();
      repeat (3) t0(1'b1, 1'b0, 64'd0);
      t0(1'b1, 1'b1, 64'd5);
      chk("f_fail", fail0, 1);
      repeat (2) t0(1'b0, 1'b0, 64'd0);
      rst0 = 1'b1;
      t0(1'b0, 1'b0, 64'd0);
      chk("f_done", done0, 0); chk("f_code", code0, 0); chk("f_halted", halted0, 0);
      chk("f_fail0", fail0, 0); chk("f_cycles", cycles0, 0); chk("f_instret", instret0, 0);
      rst0 = 1'b0;
      run_a();
      // timeout
      rst_u0();
      repeat (99) t0(1'b1, 1'b0, 64'd0);
      chk("to_done99", done0, 0); chk("to_cycles99", cycles0, 99);
      t0(1'b1, 1'b0, 64'd0);
      chk("to_done", done0, 1); chk("to_code", code0, 3); chk("to_cycles", cycles0, 100);
      repeat (3) t0(1'b1, 1'b1, 64'd0);
      chk("to_cycles_frozen", cycles0, 100); chk("to_instret_frozen", instret0, 100);
      chk("to_halted", halted0, 0);
      // stall after last commit at edge 5
      rst_u0();
      repeat (5) t0(1'b1, 1'b0, 64'd0);
      repeat (7) t0(1'b0, 1'b0, 64'd0);
      chk("st_done12", done0, 0);
      t0(1'b0, 1'b0, 64'd0);
      chk("st_done13", done0, 1); chk("st_code13", code0, 4); chk("st_cycles13", cycles0, 13);
      // stall with one late commit at edge 10
      rst_u0();
      repeat (5) t0(1'b1, 1'b0, 64'd0);
      repeat (4) t0(1'b0, 1'b0, 64'd0);
      t0(1'b1, 1'b0, 64'd0);
      repeat (7) t0(1'b0, 1'b0, 64'd0);
      chk("st2_done17", done0, 0);
      t0(1'b0, 1'b0, 64'd0);
      chk("st2_done18", done0, 1); chk("st2_code18", code0, 4); chk("st2_instret", instret0, 6);
      // last ebreak on the timeout edge takes the drain path
      rst_u0();
      repeat (99) t0(1'b1, 1'b0, 64'd0);
      t0(1'b1, 1'b1, 64'd0);
      chk("ht_done100", done0, 0); chk("ht_halted", halted0, 1); chk("ht_code100", code0, 0);
      repeat (4) t0(1'b0, 1'b0, 64'd0);
      chk("ht_done104", done0, 0);
      t0(1'b0, 1'b0, 64'd0);
      chk("ht_done105", done0, 1); chk("ht_code105", code0, 1); chk("ht_cycles", cycles0, 105);
      // ebreak without commit is ignored, then a failing halt
      rst_u0();
      t0(1'b0, 1'b1, 64'd3);
      chk("eb_halted", halted0, 0); chk("eb_instret", instret0, 0);
      t0(1'b1, 1'b1, 64'd3);
      chk("eb_halted2", halted0, 1); chk("eb_fail", fail0, 1);
      repeat (5) t0(1'b0, 1'b0, 64'd0);
      chk("eb_done", done0, 1); chk("eb_code", code0, 2);
      // two harts, no drain window, stall detection disabled
      t1(2'b00, 2'b00, 32'd0);
      rst1 = 1'b0;
      chk("m_rst_done", done1, 0); chk("m_rst_instret", instret1, 0);
      repeat (3) t1(2'b11, 2'b00, 32'd0);
      t1(2'b11, 2'b01, 32'd0);
      chk("m_halted", halted1, 2'b01); chk("m_instret4", instret1, {16'd4, 16'd4});
      chk("m_fail0", fail1, 2'b00);
      repeat (20) t1(2'b11, 2'b01, {16'd0, 16'd9});
      chk("m_instret24", instret1, {16'd24, 16'd4}); chk("m_fail_still0", fail1, 2'b00);
      chk("m_done24", done1, 0);
      repeat (20) t1(2'b00, 2'b00, 32'd0);
      chk("m_nostall", done1, 0); chk("m_cycles44", cycles1, 44);
      t1(2'b10, 2'b10, {16'd7, 16'd0});
      chk("m_done", done1, 1); chk("m_code", code1, 2); chk("m_failmask", fail1, 2'b10);
      chk("m_halted_all", halted1, 2'b11); chk("m_instret25", instret1, {16'd25, 16'd4});
      t1(2'b11, 2'b11, 32'd0);
      chk("m_cycles_frozen", cycles1, 45);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
